// File: rtl/ds_hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : ds_hazard_scoreboard_if
// Brief    : Decode/issue/writeback signal bundle for the hazard scoreboard.
// Revision : 1.0
// ============================================================================
interface ds_hazard_scoreboard_if;
    logic        ds_valid;
    logic [4:0]  ds_rs_addr;
    logic [4:0]  ds_rt_addr;
    logic        ds_rs_used;
    logic        ds_rt_used;
    logic        issue_fire;
    logic        issue_rf_we;
    logic [4:0]  issue_rf_waddr;
    logic        wb_fire;
    logic        wb_rf_we;
    logic [4:0]  wb_rf_waddr;
    logic        flush;
    logic        ds_ready_go;
    logic [31:0] busy_mask;
    logic        sb_err;
    logic [31:0] stall_cycles;

    modport master (
        output ds_valid, ds_rs_addr, ds_rt_addr, ds_rs_used, ds_rt_used,
               issue_fire, issue_rf_we, issue_rf_waddr,
               wb_fire, wb_rf_we, wb_rf_waddr, flush,
        input  ds_ready_go, busy_mask, sb_err, stall_cycles
    );

    modport slave (
        input  ds_valid, ds_rs_addr, ds_rt_addr, ds_rs_used, ds_rt_used,
               issue_fire, issue_rf_we, issue_rf_waddr,
               wb_fire, wb_rf_we, wb_rf_waddr, flush,
        output ds_ready_go, busy_mask, sb_err, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/ds_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : ds_hazard_scoreboard
// Brief    : Per-register in-flight write counters producing RAW-hazard stall.
// Revision : 1.0
// ============================================================================
module ds_hazard_scoreboard #(
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 0
) (
    input  wire                          clk,
    input  wire                          reset,
    ds_hazard_scoreboard_if.slave        sb
);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [1:31];
    logic [CNT_W-1:0] cnt_d [1:31];
    logic             sb_err_q, sb_err_d;
    logic [31:0]      stall_cycles_q, stall_cycles_d;

    logic        issue_hit, wb_hit;
    logic [31:0] busy_mask;
    logic        rs_busy, rt_busy, rs_one, rt_one;
    logic        rs_haz, rt_haz, ready_go;

    assign issue_hit = sb.issue_fire && sb.issue_rf_we && (sb.issue_rf_waddr != 5'd0);
    assign wb_hit    = sb.wb_fire && sb.wb_rf_we && (sb.wb_rf_waddr != 5'd0);

    // Source lookups only span 1..31, so an r0 source can never look busy.
    always_comb begin
        busy_mask = '0;
        rs_busy   = 1'b0;
        rt_busy   = 1'b0;
        rs_one    = 1'b0;
        rt_one    = 1'b0;
        for (int i = 1; i < 32; i++) begin
            busy_mask[i] = (cnt_q[i] != '0);
            if (sb.ds_rs_addr == 5'(i)) begin
                rs_busy = busy_mask[i];
                rs_one  = (cnt_q[i] == C_CNT_ONE);
            end
            if (sb.ds_rt_addr == 5'(i)) begin
                rt_busy = busy_mask[i];
                rt_one  = (cnt_q[i] == C_CNT_ONE);
            end
        end
    end

    always_comb begin
        rs_haz = sb.ds_rs_used && rs_busy;
        rt_haz = sb.ds_rt_used && rt_busy;
        // Write-first RF: the retiring last pending write satisfies the read now.
        if (WB_BYPASS != 0) begin
            if (wb_hit && (sb.wb_rf_waddr == sb.ds_rs_addr) && rs_one) rs_haz = 1'b0;
            if (wb_hit && (sb.wb_rf_waddr == sb.ds_rt_addr) && rt_one) rt_haz = 1'b0;
        end
        ready_go = !sb.ds_valid || !(rs_haz || rt_haz);
    end

    always_comb begin
        cnt_d          = cnt_q;
        sb_err_d       = sb_err_q;
        stall_cycles_d = stall_cycles_q;
        if (sb.ds_valid && !ready_go) stall_cycles_d = stall_cycles_q + 32'd1;
        for (int i = 1; i < 32; i++) begin
            if (sb.flush) begin
                cnt_d[i] = '0;
            end else if (issue_hit && (sb.issue_rf_waddr == 5'(i)) &&
                         !(wb_hit && (sb.wb_rf_waddr == 5'(i)))) begin
                if (cnt_q[i] == C_CNT_MAX) sb_err_d = 1'b1;
                else                       cnt_d[i] = cnt_q[i] + C_CNT_ONE;
            end else if (wb_hit && (sb.wb_rf_waddr == 5'(i)) &&
                         !(issue_hit && (sb.issue_rf_waddr == 5'(i)))) begin
                if (cnt_q[i] == '0) sb_err_d = 1'b1;
                else                cnt_d[i] = cnt_q[i] - C_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) cnt_q[i] <= '0;
            sb_err_q       <= 1'b0;
            stall_cycles_q <= 32'd0;
        end else begin
            cnt_q          <= cnt_d;
            sb_err_q       <= sb_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign sb.ds_ready_go  = ready_go;
    assign sb.busy_mask    = busy_mask;
    assign sb.sb_err       = sb_err_q;
    assign sb.stall_cycles = stall_cycles_q;
endmodule
`default_nettype wire

// File: tb/tb_ds_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_ds_hazard_scoreboard
// Brief    : Directed + random check of both bypass variants against a model.
// Revision : 1.0
// ============================================================================
module tb_ds_hazard_scoreboard;
    localparam int C_MAX = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       ds_valid, ds_rs_used, ds_rt_used, issue_fire, issue_rf_we;
    logic       wb_fire, wb_rf_we, flush;
    logic [4:0] ds_rs_addr, ds_rt_addr, issue_rf_waddr, wb_rf_waddr;

    ds_hazard_scoreboard_if if0 ();
    ds_hazard_scoreboard_if if1 ();

    assign if0.ds_valid = ds_valid;           assign if1.ds_valid = ds_valid;
    assign if0.ds_rs_addr = ds_rs_addr;       assign if1.ds_rs_addr = ds_rs_addr;
    assign if0.ds_rt_addr = ds_rt_addr;       assign if1.ds_rt_addr = ds_rt_addr;
    assign if0.ds_rs_used = ds_rs_used;       assign if1.ds_rs_used = ds_rs_used;
    assign if0.ds_rt_used = ds_rt_used;       assign if1.ds_rt_used = ds_rt_used;
    assign if0.issue_fire = issue_fire;       assign if1.issue_fire = issue_fire;
    assign if0.issue_rf_we = issue_rf_we;     assign if1.issue_rf_we = issue_rf_we;
    assign if0.issue_rf_waddr = issue_rf_waddr; assign if1.issue_rf_waddr = issue_rf_waddr;
    assign if0.wb_fire = wb_fire;             assign if1.wb_fire = wb_fire;
    assign if0.wb_rf_we = wb_rf_we;           assign if1.wb_rf_we = wb_rf_we;
    assign if0.wb_rf_waddr = wb_rf_waddr;     assign if1.wb_rf_waddr = wb_rf_waddr;
    assign if0.flush = flush;                 assign if1.flush = flush;

    ds_hazard_scoreboard #(.CNT_W(2), .WB_BYPASS(0)) u_dut0 (.clk(clk), .reset(reset), .sb(if0.slave));
    ds_hazard_scoreboard #(.CNT_W(2), .WB_BYPASS(1)) u_dut1 (.clk(clk), .reset(reset), .sb(if1.slave));

    int          m_cnt [32];
    bit          m_err;
    int unsigned m_stall0, m_stall1;
    int          n_cmp = 0;
    int          n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_err = 0; m_stall0 = 0; m_stall1 = 0;
    endtask

    function automatic bit hazard(input int s, input bit used, input bit byp);
        bit h;
        h = used && (s != 0) && (m_cnt[s] > 0);
        if (byp && wb_fire && wb_rf_we && (int'(wb_rf_waddr) == s) && (m_cnt[s] == 1)) h = 0;
        return h;
    endfunction

    function automatic bit exp_ready(input bit byp);
        if (!ds_valid) return 1;
        return !(hazard(int'(ds_rs_addr), ds_rs_used, byp) || hazard(int'(ds_rt_addr), ds_rt_used, byp));
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] b = '0;
        for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    task automatic model_edge(input bit r0, input bit r1);
        int ia, wa;
        bit iv, wv;
        if (reset) begin model_clear(); return; end
        if (ds_valid && !r0) m_stall0++;
        if (ds_valid && !r1) m_stall1++;
        if (flush) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            return;
        end
        ia = int'(issue_rf_waddr); wa = int'(wb_rf_waddr);
        iv = issue_fire && issue_rf_we && ia != 0;
        wv = wb_fire && wb_rf_we && wa != 0;
        if (iv && wv && ia == wa) return;
        if (iv) begin
            if (m_cnt[ia] == C_MAX) m_err = 1; else m_cnt[ia]++;
        end
        if (wv) begin
            if (m_cnt[wa] == 0) m_err = 1; else m_cnt[wa]--;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy0"},  if0.busy_mask, exp_busy());
        chk({tag, ".busy1"},  if1.busy_mask, exp_busy());
        chk({tag, ".ready0"}, 32'(if0.ds_ready_go), 32'(exp_ready(0)));
        chk({tag, ".ready1"}, 32'(if1.ds_ready_go), 32'(exp_ready(1)));
        chk({tag, ".err0"},   32'(if0.sb_err), 32'(m_err));
        chk({tag, ".err1"},   32'(if1.sb_err), 32'(m_err));
        chk({tag, ".stall0"}, if0.stall_cycles, m_stall0);
        chk({tag, ".stall1"}, if1.stall_cycles, m_stall1);
    endtask

    // Called just after a negedge with inputs set; checks, then crosses one posedge.
    task automatic step(input string tag);
        bit r0, r1;
        #1;
        check_all(tag);
        r0 = exp_ready(0); r1 = exp_ready(1);
        @(posedge clk);
        model_edge(r0, r1);
        @(negedge clk);
    endtask

    task automatic idle();
        ds_valid = 0; ds_rs_addr = 0; ds_rt_addr = 0; ds_rs_used = 0; ds_rt_used = 0;
        issue_fire = 0; issue_rf_we = 0; issue_rf_waddr = 0;
        wb_fire = 0; wb_rf_we = 0; wb_rf_waddr = 0; flush = 0;
    endtask

    task automatic iss(input int a);
        issue_fire = 1; issue_rf_we = 1; issue_rf_waddr = 5'(a);
    endtask

    task automatic cmt(input int a);
        wb_fire = 1; wb_rf_we = 1; wb_rf_waddr = 5'(a);
    endtask

    initial begin
        int unsigned err_hold, stall_hold;
        idle();
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        step("reset_state");

        // Pending write to r5 blocks an rs read until it retires.
        iss(5); step("i5");
        idle(); ds_valid = 1; ds_rs_addr = 5; ds_rs_used = 1;
        #1 chk("req032_busy", if0.busy_mask, 32'h20);
        chk("req032_ready", 32'(if0.ds_ready_go), 32'd0);
        step("raw5_a");
        step("raw5_b");
        chk("req032_stall", if0.stall_cycles, 32'd2);
        cmt(5); step("wb5");
        wb_fire = 0; wb_rf_we = 0;
        #1 chk("req032_clear", if0.busy_mask, 32'h0);
        chk("req032_go", 32'(if0.ds_ready_go), 32'd1);
        step("after5");

        // Bypass on the last pending write only.
        idle(); iss(7); step("i7");
        idle(); ds_valid = 1; ds_rt_addr = 7; ds_rt_used = 1; cmt(7);
        #1 chk("req033_byp_go", 32'(if1.ds_ready_go), 32'd1);
        chk("req033_nobyp", 32'(if0.ds_ready_go), 32'd0);
        step("byp7_1");
        idle(); iss(7); step("i7a"); step("i7b");
        ds_valid = 1; ds_rt_addr = 7; ds_rt_used = 1; issue_fire = 0; cmt(7);
        #1 chk("req033_byp_cnt2", 32'(if1.ds_ready_go), 32'd0);
        step("byp7_2");
        idle(); cmt(7); step("drain7");

        // Same-register issue+commit cancels; different registers both apply.
        idle(); iss(3); step("i3");
        cmt(3); step("i3c3");
        idle();
        #1 chk("req034_busy3", 32'(if0.busy_mask[3]), 32'd1);
        iss(4); cmt(3); step("i4c3");
        idle();
        #1 chk("req034_mask", if0.busy_mask & 32'h18, 32'h10);
        cmt(4); step("drain4");

        // Saturation and underflow.
        idle(); iss(9);
        repeat (4) step("i9");
        idle();
        #1 chk("req035_err", 32'(if0.sb_err), 32'd1);
        cmt(2); step("c2_underflow");
        idle();
        #1 chk("req035_cnt2", 32'(if0.busy_mask[2]), 32'd0);
        repeat (3) begin cmt(9); step("drain9"); end

        // r0 is never tracked.
        idle(); ds_valid = 1; ds_rs_addr = 0; ds_rs_used = 1; iss(0); step("r0_a");
        issue_fire = 0;
        #1 chk("req036_busy", if0.busy_mask, 32'h0);
        chk("req036_go", 32'(if0.ds_ready_go), 32'd1);
        step("r0_b");

        // Flush clears counts but not err or stall counters.
        idle(); iss(1); step("i1"); iss(2); step("i2"); iss(31); step("i31");
        idle(); ds_valid = 1; ds_rs_addr = 31; ds_rs_used = 1; step("stall31");
        err_hold = 32'(if0.sb_err); stall_hold = if0.stall_cycles;
        idle(); flush = 1; iss(5); step("flush");
        idle();
        #1 chk("req037_flush_busy", if0.busy_mask, 32'h0);
        chk("req037_err_kept", 32'(if0.sb_err), err_hold);
        chk("req037_stall_kept", if0.stall_cycles, stall_hold);
        step("post_flush");

        // Asynchronous reset mid-cycle; inputs ignored while it is high.
        iss(6); step("i6");
        idle(); ds_valid = 1; ds_rs_addr = 6; ds_rs_used = 1;
        #2 reset = 1;
        #1 model_clear();
        chk("async_busy", if0.busy_mask, 32'h0);
        chk("async_err", 32'(if0.sb_err), 32'd0);
        chk("async_stall", if0.stall_cycles, 32'd0);
        chk("async_go", 32'(if0.ds_ready_go), 32'd1);
        @(negedge clk);
        idle(); iss(8); flush = 0;
        step("in_reset");
        reset = 0; idle();
        step("after_reset");

        // Random traffic on a small register window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            ds_valid       = ($urandom_range(0, 3) != 0);
            ds_rs_addr     = 5'($urandom_range(0, 7));
            ds_rt_addr     = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            ds_rs_used     = 1'($urandom);
            ds_rt_used     = 1'($urandom);
            issue_fire     = 1'($urandom);
            issue_rf_we    = ($urandom_range(0, 3) != 0);
            issue_rf_waddr = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            wb_fire        = 1'($urandom);
            wb_rf_we       = ($urandom_range(0, 3) != 0);
            wb_rf_waddr    = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            flush          = ($urandom_range(0, 31) == 0);
            step("rand");
        end
        idle();
        step("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ds_hazard_scoreboard.md
DS_HAZARD_SCOREBOARD -- requirements
Module: ds_hazard_scoreboard

Interface
REQ-001 Parameter CNT_W, default 2: per-register in-flight counter width; max count 2^CNT_W-1.
REQ-002 Parameter WB_BYPASS, default 0: 1 = a same-cycle commit that drains the last pending write clears the hazard (RF is write-first).
REQ-003 clk  in  1  single clock; all state rises on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 ds_valid  in  1  decode stage holds a valid instruction.
REQ-006 ds_rs_addr, ds_rt_addr  in  5 each  source register addresses.
REQ-007 ds_rs_used, ds_rt_used  in  1 each  the instruction actually reads rs/rt.
REQ-008 issue_fire  in  1  decode-to-execute handshake completes this cycle (ds_to_es_valid && es_allowin).
REQ-009 issue_rf_we, issue_rf_waddr  in  1, 5  destination of the issuing instruction.
REQ-010 wb_fire  in  1  writeback retires an instruction this cycle.
REQ-011 wb_rf_we, wb_rf_waddr  in  1, 5  destination being written to the RF.
REQ-012 flush  in  1  synchronous clear of all pending state.
REQ-013 ds_ready_go  out  1  no RAW hazard on the decode instruction's used sources.
REQ-014 busy_mask  out  32  bit i = register i has pending writes.
REQ-015 sb_err  out  1  sticky overflow/underflow flag.
REQ-016 stall_cycles  out  32  count of cycles with ds_valid && !ds_ready_go.

Function
REQ-017 The block SHALL hold one CNT_W-bit counter per register 1..31; register 0 is never tracked, and busy_mask[0] is always 0.
REQ-018 Issue: issue_fire && issue_rf_we && issue_rf_waddr!=0 SHALL increment cnt[issue_rf_waddr] at the next edge.
REQ-019 Commit: wb_fire && wb_rf_we && wb_rf_waddr!=0 SHALL decrement cnt[wb_rf_waddr] at the next edge.
REQ-020 Issue and commit to the same register in the same cycle SHALL leave the count unchanged; to different registers, both SHALL apply.
REQ-021 Increment at max count SHALL saturate (no wrap) and set sb_err.
REQ-022 Decrement at count 0 SHALL leave the count at 0 and set sb_err.
REQ-023 busy_mask[i] SHALL be (cnt[i]!=0), decoded from registered state; zero latency.
REQ-024 Hazard for src s SHALL be s_used && s!=0 && busy_mask[s]; with WB_BYPASS=1 it is masked when wb_fire && wb_rf_we && wb_rf_waddr==s && cnt[s]==1.
REQ-025 ds_ready_go SHALL be the NOR of the rs and rt hazards; it SHALL NOT depend on issue_fire (no combinational loop).
REQ-026 ds_ready_go SHALL be 1 when ds_valid=0, independent of source addresses.
REQ-027 flush SHALL zero all counters at the next edge and override same-cycle issue/commit; it SHALL NOT clear sb_err or stall_cycles.
REQ-028 stall_cycles SHALL increment by 1 per cycle with ds_valid && !ds_ready_go and wrap modulo 2^32.
REQ-029 sb_err, once set, SHALL stay 1 until reset.

Reset
REQ-030 On reset assertion the block SHALL zero all counters, busy_mask, sb_err and stall_cycles asynchronously; ds_ready_go SHALL then be 1.
REQ-031 While reset is high, issue, commit and flush SHALL have no effect; the first update occurs at the first posedge after deassertion.

Verification
REQ-032 Issue r5 (issue_fire, we=1, waddr=5), then decode rs=5 used -> busy_mask=0x20, ds_ready_go=0, stall_cycles increments each cycle; commit r5 -> busy_mask=0 and ds_ready_go=1 on the next cycle (WB_BYPASS=0).
REQ-033 WB_BYPASS=1, cnt[7]=1, decode rt=7 used, same-cycle wb_fire to r7 -> ds_ready_go=1 in that cycle; with cnt[7]=2 -> ds_ready_go=0.
REQ-034 Issue to r3 and commit to r3 in the same cycle with cnt[3]=1 -> cnt[3] stays 1 and busy_mask[3]=1; issue to r4 with commit to r3 -> cnt[4]+1, cnt[3]-1.
REQ-035 Four issues to r9 without commit (CNT_W=2) -> cnt[9]=3 and sb_err=1; a commit to r2 at count 0 -> sb_err=1 and cnt[2]=0.
REQ-036 Issue and decode on r0 (rs=0 used, waddr=0) -> busy_mask=0 and ds_ready_go=1.
REQ-037 Pending writes to r1, r2 and r31, then flush -> busy_mask=0 next cycle, sb_err and stall_cycles unchanged; asynchronous reset asserted mid-cycle -> all outputs at reset values before the next edge.
